accum_alu_pipe: RTL

- Parametrised successor to the tile's combinational 8-bit adder: a 2-stage pipelined unsigned ALU with a persistent accumulator, selectable modes, optional saturation and valid/ready handshakes on both sides.
- Instantiated under the tile top; the top maps ui_in/uio_in to operands and opcode, and uo_out to result/flags.
- Wrapper pin mapping is the top's concern, not this block's.

---
 rtl/accum_alu_pkg.sv | 17 +
 rtl/accum_alu_core.sv | 60 ++++++
 rtl/accum_alu_pipe.sv | 95 +++++++++
 3 files changed

// File: rtl/accum_alu_pkg.sv
// rtl/accum_alu_pkg.sv - shared opcode definitions for the pipelined accumulator ALU
package accum_alu_pkg;

    localparam int OP_W = 3;

    typedef logic [OP_W-1:0] op_t;

    localparam op_t OP_ADD  = 3'd0;
    localparam op_t OP_SUB  = 3'd1;
    localparam op_t OP_ACC  = 3'd2;
    localparam op_t OP_CLR  = 3'd3;
    localparam op_t OP_LOAD = 3'd4;
    localparam op_t OP_AND  = 3'd5;
    localparam op_t OP_XOR  = 3'd6;
    localparam op_t OP_RSVD = 3'd7;

endpackage

// File: rtl/accum_alu_core.sv
// rtl/accum_alu_core.sv - combinational result/flag/next-accumulator compute
module accum_alu_core
    import accum_alu_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int SATURATE = 0
) (
    input  op_t              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] acc_nxt,
    output logic             carry,
    output logic             err
);

    localparam logic [WIDTH-1:0] ONES = '1;

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic [WIDTH:0] acc_sum;

    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        diff    = {1'b0, a} - {1'b0, b};
        acc_sum = {1'b0, acc} + {1'b0, a};
        result  = '0;
        acc_nxt = acc;
        carry   = 1'b0;
        err     = 1'b0;
        case (op)
            OP_ADD: begin
                carry  = sum[WIDTH];
                result = (SATURATE != 0 && carry) ? ONES : sum[WIDTH-1:0];
            end
            // diff[WIDTH] is set exactly when a < b
            OP_SUB: begin
                carry  = diff[WIDTH];
                result = (SATURATE != 0 && carry) ? '0 : diff[WIDTH-1:0];
            end
            OP_ACC: begin
                carry   = acc_sum[WIDTH];
                result  = (SATURATE != 0 && carry) ? ONES : acc_sum[WIDTH-1:0];
                acc_nxt = result;
            end
            OP_CLR: begin
                acc_nxt = '0;
            end
            OP_LOAD: begin
                result  = a;
                acc_nxt = a;
            end
            OP_AND: result = a & b;
            OP_XOR: result = a ^ b;
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/accum_alu_pipe.sv
// rtl/accum_alu_pipe.sv - 2-stage valid/ready ALU pipeline with persistent accumulator
module accum_alu_pipe
    import accum_alu_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int SATURATE = 0,
    parameter int OP_W     = accum_alu_pkg::OP_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_err,
    output logic [WIDTH-1:0] acc_q
);

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } s1_t;

    s1_t              s1;
    logic             s1_valid;
    logic             s2_valid;
    logic [WIDTH-1:0] acc;

    logic [WIDTH-1:0] res_c;
    logic [WIDTH-1:0] acc_c;
    logic             carry_c;
    logic             err_c;
    logic             s1_adv;
    logic             s1_load;

    accum_alu_core #(
        .WIDTH    (WIDTH),
        .SATURATE (SATURATE)
    ) u_core (
        .op      (s1.op),
        .a       (s1.a),
        .b       (s1.b),
        .acc     (acc),
        .result  (res_c),
        .acc_nxt (acc_c),
        .carry   (carry_c),
        .err     (err_c)
    );

    // S1 may refill in the same cycle it drains, so throughput stays at one op per cycle
    assign s1_adv    = s1_valid && (!s2_valid || out_ready);
    assign s1_load   = !s1_valid || s1_adv;
    assign in_ready  = rst_n && ena && s1_load;
    assign out_valid = s2_valid;
    assign acc_q     = acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1        <= '0;
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_data  <= '0;
            out_carry <= 1'b0;
            out_zero  <= 1'b0;
            out_err   <= 1'b0;
            acc       <= '0;
        end else if (ena) begin
            if (s1_adv) begin
                s2_valid  <= 1'b1;
                out_data  <= res_c;
                out_carry <= carry_c;
                out_zero  <= (res_c == '0);
                out_err   <= err_c;
                acc       <= acc_c;
            end else if (out_ready) begin
                s2_valid  <= 1'b0;
            end
            if (s1_load) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1 <= '{op: op, a: a, b: b};
                end
            end
        end
    end

endmodule
